// File: rtl/huber_loss_stream.sv
// Streaming Huber (smooth-L1) loss: two-stage pipeline (difference, element loss)
// followed by an optional per-frame sum/mean reduction with valid/ready handshakes.
module huber_loss_stream #(
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 8,
    parameter int BETA_LOG2 = 0,
    parameter int LOG2_N    = 4,
    parameter int REDUCTION = 2,
    localparam int LW       = DATA_W + 1,
    localparam int OUT_W    = LW + LOG2_N
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic signed [DATA_W-1:0] pred_in,
    input  logic signed [DATA_W-1:0] target_in,
    input  logic                     clr,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [OUT_W-1:0]         loss_out
);

    localparam int SQ_W  = 2 * LW;
    localparam int SHIFT = FRAC_W + 1 + BETA_LOG2;
    localparam logic [LW-1:0] BETA_FX   = {{(LW-1){1'b0}}, 1'b1} << (FRAC_W + BETA_LOG2);
    localparam logic [LW-1:0] HALF_BETA = BETA_FX >> 1;

    logic                 valid_out_q;
    logic [OUT_W-1:0]     loss_out_q;
    logic                 s1_valid_q;
    logic signed [LW-1:0] diff_q;

    logic                 advance;
    logic                 accept;
    logic [LW-1:0]        abs_d;
    logic [SQ_W-1:0]      sq;
    logic [LW-1:0]        elem_loss;
    logic                 load_result;
    logic [OUT_W-1:0]     result_d;

    // A full output register blocks the whole pipe until downstream takes it.
    assign advance  = !valid_out_q || ready_out;
    assign ready_in = rst_n && !clr && advance;
    assign accept   = valid_in && ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            diff_q     <= '0;
        end else if (clr) begin
            s1_valid_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= accept;
            if (accept) begin
                diff_q <= {pred_in[DATA_W-1], pred_in} - {target_in[DATA_W-1], target_in};
            end
        end
    end

    // |d| never reaches -2^DATA_W, so the magnitude always fits LW unsigned bits.
    assign abs_d = diff_q[LW-1] ? (~diff_q + 1'b1) : diff_q;
    assign sq    = {{LW{1'b0}}, abs_d} * {{LW{1'b0}}, abs_d};

    always_comb begin
        elem_loss = abs_d - HALF_BETA;
        if (abs_d < BETA_FX) begin
            elem_loss = LW'(sq >> SHIFT);
        end
    end

    generate
        if (REDUCTION == 0) begin : g_elem
            assign load_result = s1_valid_q && !clr;
            assign result_d    = {{LOG2_N{1'b0}}, elem_loss};
        end else begin : g_frame
            logic [LOG2_N-1:0] cnt_q;
            logic [OUT_W-1:0]  acc_q;
            logic [OUT_W-1:0]  sum_d;

            // Loading (not adding) at count 0 lets frames run back to back.
            assign sum_d = ((cnt_q == '0) ? '0 : acc_q) + {{LOG2_N{1'b0}}, elem_loss};
            assign load_result = s1_valid_q && !clr && (&cnt_q);
            assign result_d    = (REDUCTION == 1) ? sum_d : (sum_d >> LOG2_N);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    acc_q <= '0;
                end else if (clr) begin
                    cnt_q <= '0;
                    acc_q <= '0;
                end else if (advance && s1_valid_q) begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= sum_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_q <= 1'b0;
            loss_out_q  <= '0;
        end else if (advance) begin
            valid_out_q <= load_result;
            if (load_result) begin
                loss_out_q <= result_d;
            end
        end
    end

    assign valid_out = valid_out_q;
    assign loss_out  = loss_out_q;

endmodule

// File: tb/tb_huber_loss_stream.sv
// Bench for huber_loss_stream: three instances (per-element, sum, mean; N=4) share one
// input stream and are checked against a frame-level scoreboard model.
module tb_huber_loss_stream;

    localparam int DATA_W    = 16;
    localparam int FRAC_W    = 8;
    localparam int BETA_LOG2 = 0;
    localparam int LOG2_N    = 2;
    localparam int N         = 1 << LOG2_N;
    localparam int OUT_W     = DATA_W + 1 + LOG2_N;
    localparam int NDUT      = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic                     valid_in;
    logic                     clr;
    logic signed [DATA_W-1:0] pred_in;
    logic signed [DATA_W-1:0] target_in;
    logic                     ready_out   [NDUT];
    logic                     ready_in_w  [NDUT];
    logic                     valid_out_w [NDUT];
    logic [OUT_W-1:0]         loss_w      [NDUT];

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            huber_loss_stream #(
                .DATA_W(DATA_W), .FRAC_W(FRAC_W), .BETA_LOG2(BETA_LOG2),
                .LOG2_N(LOG2_N), .REDUCTION(gi)
            ) u_dut (
                .clk(clk), .rst_n(rst_n),
                .valid_in(valid_in), .ready_in(ready_in_w[gi]),
                .pred_in(pred_in), .target_in(target_in), .clr(clr),
                .valid_out(valid_out_w[gi]), .ready_out(ready_out[gi]),
                .loss_out(loss_w[gi])
            );
        end
    endgenerate

    int n_vec = 0;
    int n_err = 0;

    int               exp_q       [NDUT][$];
    int               frame_sum   [NDUT];
    int               frame_cnt   [NDUT];
    bit               prev_pushed [NDUT];
    bit               hold_v      [NDUT];
    logic [OUT_W-1:0] hold_val    [NDUT];

    int lit_p [5] = '{'h0000, 'h0100, 'h00FF, 'h7FFF, 'h0180};
    int lit_t [5] = '{'h0080, 0, 0, -32768, 0};
    int lit_l [5] = '{'h00020, 'h00080, 'h0007F, 'h0FF7F, 'h00100};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int ref_loss(input int p, input int t);
        int a;
        int beta;
        a    = p - t;
        if (a < 0) a = -a;
        beta = 1 << (FRAC_W + BETA_LOG2);
        if (a < beta) return (a * a) >>> (FRAC_W + 1 + BETA_LOG2);
        return a - beta / 2;
    endfunction

    // Scoreboard update for one accepted sample on instance k (REDUCTION == k).
    task automatic model_accept(input int k, input int l);
        prev_pushed[k] = 1'b0;
        if (k == 0) begin
            exp_q[k].push_back(l);
            prev_pushed[k] = 1'b1;
        end else begin
            frame_sum[k] += l;
            frame_cnt[k]++;
            if (frame_cnt[k] == N) begin
                exp_q[k].push_back((k == 1) ? frame_sum[k] : (frame_sum[k] >> LOG2_N));
                prev_pushed[k] = 1'b1;
                frame_sum[k]   = 0;
                frame_cnt[k]   = 0;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            exp_q[k].delete();
            frame_sum[k]   = 0;
            frame_cnt[k]   = 0;
            prev_pushed[k] = 1'b0;
            hold_v[k]      = 1'b0;
        end
    endtask

    // Called at the falling edge: evaluates what the next rising edge will commit.
    task automatic monitor();
        for (int k = 0; k < NDUT; k++) begin
            logic rin, vo, ro;
            logic [OUT_W-1:0] lo;
            bit acc;
            rin = ready_in_w[k];
            vo  = valid_out_w[k];
            ro  = ready_out[k];
            lo  = loss_w[k];
            check_val($sformatf("ready_in[%0d]", k), rin, !clr && (!vo || ro));
            if (hold_v[k]) begin
                check_val($sformatf("hold_valid[%0d]", k), vo, 1);
                check_val($sformatf("hold_data[%0d]", k), lo, hold_val[k]);
            end
            if (vo && ro) begin
                if (exp_q[k].size() == 0) check_val($sformatf("spurious_out[%0d]", k), vo, 0);
                else check_val($sformatf("result[%0d]", k), lo, exp_q[k].pop_front());
            end
            acc = valid_in && rin;
            if (acc) model_accept(k, ref_loss(int'(pred_in), int'(target_in)));
            else if (clr) begin
                // clr is only used with the pipe unstalled, so the stage-1 occupant is
                // the sample accepted on the previous edge; its result never appears.
                if (prev_pushed[k] && exp_q[k].size() > 0) void'(exp_q[k].pop_back());
                frame_sum[k] = 0;
                frame_cnt[k] = 0;
            end
            if (!acc) prev_pushed[k] = 1'b0;
            hold_v[k]   = vo && !ro;
            hold_val[k] = lo;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int p, input int t);
        valid_in  = v;
        pred_in   = DATA_W'(p);
        target_in = DATA_W'(t);
    endtask

    task automatic set_ready(input bit r);
        for (int k = 0; k < NDUT; k++) ready_out[k] = r;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0);
        repeat (n) cycle();
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        clr   = 1'b0;
        drive(0, 0, 0);
        set_ready(1);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check_val($sformatf("rst_valid_out[%0d]", k), valid_out_w[k], 0);
            check_val($sformatf("rst_loss_out[%0d]", k), loss_w[k], 0);
            check_val($sformatf("rst_ready_in[%0d]", k), ready_in_w[k], 0);
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++)
            check_val($sformatf("post_rst_ready_in[%0d]", k), ready_in_w[k], 1);

        // Two-cycle latency of the per-element instance.
        drive(1, 'h0180, 0);
        cycle();
        drive(0, 0, 0);
        check_val("r0_latency_early", valid_out_w[0], 0);
        cycle();
        check_val("r0_latency_valid", valid_out_w[0], 1);
        check_val("r0_latency_data", loss_w[0], 'h100);

        // Boundary values back to back; each result shows two cycles after its accept.
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) drive(1, lit_p[i], lit_t[i]);
            else drive(0, 0, 0);
            cycle();
            if (i >= 1) begin
                check_val($sformatf("r0_boundary_valid[%0d]", i - 1), valid_out_w[0], 1);
                check_val($sformatf("r0_boundary_data[%0d]", i - 1), loss_w[0], lit_l[i - 1]);
            end
        end
        idle(3);

        // Frame-aligned sum/mean of four d=0x0180 samples.
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 'h0180, 0);
            cycle();
        end
        drive(0, 0, 0);
        check_val("frame_early_valid", valid_out_w[1], 0);
        cycle();
        check_val("sum_valid", valid_out_w[1], 1);
        check_val("sum_data", loss_w[1], 'h400);
        check_val("mean_valid", valid_out_w[2], 1);
        check_val("mean_data", loss_w[2], 'h100);
        idle(3);

        // Eight back-to-back random samples: two frame results, no bubble.
        pulses = 0;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive(1, int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000);
            else drive(0, 0, 0);
            cycle();
            if (valid_out_w[1]) pulses++;
        end
        check_val("b2b_frame_count", pulses, 2);

        // clr after two accepts discards them; the next four d=0x0100 give only 0x200.
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1, 'h0100, 0);
            cycle();
        end
        drive(0, 0, 0);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 'h0100, 0);
            cycle();
            if (valid_out_w[1]) pulses++;
        end
        drive(0, 0, 0);
        cycle();
        check_val("clr_sum_data", loss_w[1], 'h200);
        for (int i = 0; i < 4; i++) begin
            if (valid_out_w[1]) pulses++;
            cycle();
        end
        check_val("clr_result_count", pulses, 1);

        // Backpressure: results stall while ready_out is low and inputs keep offering.
        set_ready(0);
        for (int i = 0; i < 7; i++) begin
            drive(1, int'($urandom_range(0, 2000)), int'($urandom_range(0, 2000)));
            cycle();
        end
        check_val("bp_valid_held", valid_out_w[0], 1);
        check_val("bp_ready_in_low", ready_in_w[0], 0);

        // Asynchronous reset in the middle of a frame with a result pending.
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check_val($sformatf("async_rst_valid[%0d]", k), valid_out_w[k], 0);
            check_val($sformatf("async_rst_loss[%0d]", k), loss_w[k], 0);
        end
        model_reset();
        drive(0, 0, 0);
        set_ready(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_val("rerelease_ready_in", ready_in_w[1], 1);

        // Random traffic with independent random backpressure per instance.
        for (int i = 0; i < 1500; i++) begin
            int t;
            t = int'($urandom_range(0, 32000)) - 16000;
            if ($urandom_range(0, 1) == 0)
                drive($urandom_range(0, 9) < 7, int'($signed(DATA_W'($urandom))), int'($signed(DATA_W'($urandom))));
            else
                drive($urandom_range(0, 9) < 7, t + int'($urandom_range(0, 600)) - 300, t);
            for (int k = 0; k < NDUT; k++) ready_out[k] = ($urandom_range(0, 9) < 6);
            cycle();
        end

        set_ready(1);
        idle(10);
        for (int k = 0; k < NDUT; k++)
            check_val($sformatf("drain_pending[%0d]", k), exp_q[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
